shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port req_valid, input, 1 bit: the requester presents a shift command.
REQ-004 The block SHALL have port req_ready, output, 1 bit: the block can accept a command.
REQ-005 The block SHALL have port req_data, input, 16 bits: the operand.
REQ-006 The block SHALL have port req_amt, input, 4 bits: the shift amount, 0..15.
REQ-007 The block SHALL have port req_mode, input, 2 bits: 00 SLL, 01 SRA, 10 ROR, 11 reserved.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: the result is available.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port rsp_data, output, 16 bits: the shifted result.
REQ-011 The block SHALL have port rsp_flag, output, 3 bits: Z, V and N at the shared flag indices.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 req_ready SHALL be 1 only in IDLE; a command is accepted on an edge where req_valid and req_ready are both 1.
REQ-015 On accept, the block SHALL:
- latch operand and mode;
- convert req_amt to three base-3 digits d0 (weight 1), d1 (weight 3) and d2 (weight 9), each encoded 2'b00/01/10 (15 -> d2=1, d1=2, d0=0);
- clear the digit index k to 0;
- enter SHIFT.
REQ-016 Each SHIFT cycle SHALL apply digit k to the working register, shifting by dk*3^k:
- SLL: zero fill;
- SRA: sign fill from the current bit 15;
- ROR: rotate right.
REQ-017 After k=2 is applied, the FSM SHALL enter DONE.
REQ-018 Latency without early exit SHALL be fixed: rsp_valid rises 3 clocks after the accepting edge.
REQ-019 In DONE:
- rsp_valid SHALL be 1;
- rsp_data and rsp_flag SHALL be stable until rsp_valid and rsp_ready are both 1;
- on that handshake edge the FSM SHALL return to IDLE, with rsp_valid low and req_ready high in the next cycle.
REQ-020 rsp_flag Z SHALL be 1 exactly when rsp_data == 0; V and N SHALL be 0.
REQ-021 Mode 11 SHALL still take the normal SHIFT sequence and SHALL produce rsp_data 0 with Z = 1.
REQ-022 req_data, req_amt and req_mode changing after accept SHALL have no effect on the result in flight.
REQ-023 rsp_ready asserted outside DONE SHALL be ignored.
REQ-024 A new command SHALL NOT be accepted in the same cycle as the response handshake (req_ready is 0 in DONE).

Reset
REQ-025 rst SHALL force, on the next edge, from any state including mid-SHIFT:
- state IDLE;
- k = 0;
- working register = 0;
- rsp_data = 0, rsp_flag = 0, rsp_valid = 0;
- busy = 0, req_ready = 1.
REQ-026 An operation interrupted by reset SHALL be discarded with no response; rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-027 With SHIFT_SEQ_EARLY_EXIT_EN defined, SHIFT SHALL go to DONE immediately after applying digit k whenever all higher digits are zero:
- amounts 0..2 give a latency of 1;
- amounts 3..8 give a latency of 2;
- amounts 9..15 give a latency of 3.
REQ-028 Without SHIFT_SEQ_EARLY_EXIT_EN, latency SHALL always be 3 (REQ-018).
REQ-029 Results and flags SHALL be identical with and without SHIFT_SEQ_EARLY_EXIT_EN.

Structure
REQ-030 A shared package SHALL hold:
- the mode encodings (SLL/SRA/ROR/RSVD);
- the flag bit indices FLAG_Z, FLAG_V and FLAG_N;
- the FSM state enumeration;
- the 2-bit base-3 digit type.
REQ-031 A single combinational sub-module shift_stage SHALL take operand, mode, digit and stage index and return the one-stage result; it SHALL be instantiated once and reused every SHIFT cycle.

Verification
REQ-032 The bench SHALL cover these scenarios:
- SLL 0x0001 by 15 -> rsp_data 0x8000, Z=0, rsp_valid 3 clocks after accept.
- SRA 0x8000 by 4 -> 0xF800; ROR 0x1234 by 4 -> 0x4123.
- SLL 0x8000 by 1 -> 0x0000, Z=1; mode 11 on 0xFFFF by 5 -> 0x0000, Z=1.
- Hold rsp_ready low 5 cycles in DONE -> rsp_data and rsp_flag stable and req_ready low throughout; release -> IDLE the next cycle.
- Assert rst during the second SHIFT cycle -> next cycle IDLE, rsp_valid 0, rsp_data 0; a new command then completes correctly.
- With SHIFT_SEQ_EARLY_EXIT_EN, amounts 2, 3 and 9 -> latencies 1, 2 and 3; without the macro, all 3.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// ----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift_seq slice:
//   - mode_t     : shift mode encodings (SLL / SRA / ROR / reserved)
//   - FLAG_*     : bit indices into the 3-bit response flag vector
//   - state_t    : sequencer FSM states
//   - digit_t    : one base-3 digit of the shift amount (2'b00/01/10)
//   - digits_t   : the three digits of a 4-bit amount, d2 (x9) d1 (x3) d0 (x1)
//   - to_base3() : amount -> digits conversion
// ----------------------------------------------------------------------------
package shift_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SLL  = 2'b00,
        MODE_SRA  = 2'b01,
        MODE_ROR  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [1:0] digit_t;

    typedef struct packed {
        digit_t d2;
        digit_t d1;
        digit_t d0;
    } digits_t;

    // Comparison/subtract form keeps this a small constant network
    // rather than a general divider.
    function automatic digits_t to_base3(input logic [3:0] amt);
        digits_t    r;
        logic [3:0] rem9;
        logic [3:0] rem3;
        r.d2 = (amt >= 4'd9) ? 2'd1 : 2'd0;
        rem9 = (amt >= 4'd9) ? (amt - 4'd9) : amt;
        if (rem9 >= 4'd6) begin
            r.d1 = 2'd2;
            rem3 = rem9 - 4'd6;
        end else if (rem9 >= 4'd3) begin
            r.d1 = 2'd1;
            rem3 = rem9 - 4'd3;
        end else begin
            r.d1 = 2'd0;
            rem3 = rem9;
        end
        r.d0 = rem3[1:0];
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// ----------------------------------------------------------------------------
// shift_seq_if
// Request/response handshake bundle for shift_seq.
//   req_valid/req_ready : command handshake
//   req_data  [15:0]    : operand
//   req_amt   [3:0]     : shift amount 0..15
//   req_mode  [1:0]     : 00 SLL, 01 SRA, 10 ROR, 11 reserved
//   rsp_valid/rsp_ready : result handshake
//   rsp_data  [15:0]    : shifted result
//   rsp_flag  [2:0]     : Z/V/N at shift_seq_pkg::FLAG_* indices
// Modports: master = requester/consumer side, slave = shift_seq side.
// ----------------------------------------------------------------------------
interface shift_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [3:0]  req_amt;
    logic [1:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_flag;

    modport master (
        output req_valid, req_data, req_amt, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_flag
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_flag
    );

endinterface

// File: rtl/shift_seq_stage.sv
// ----------------------------------------------------------------------------
// shift_stage
// Combinational single stage of the base-3 shifter: shifts operand_i by
// digit_i * 3^stage_i according to mode_i.
//   operand_i [15:0] : current working value
//   mode_i           : SLL zero fill / SRA sign fill / ROR rotate / RSVD -> 0
//   digit_i          : base-3 digit 0..2
//   stage_i   [1:0]  : digit weight index 0..2 (weights 1, 3, 9)
//   result_o  [15:0] : stage result
// ----------------------------------------------------------------------------
module shift_stage
    import shift_seq_pkg::*;
(
    input  logic [15:0] operand_i,
    input  mode_t       mode_i,
    input  digit_t      digit_i,
    input  logic [1:0]  stage_i,
    output logic [15:0] result_o
);

    logic [4:0]  amt;
    logic [3:0]  rot;
    logic [31:0] dbl;
    logic [31:0] dbl_sh;

    always_comb begin
        case (stage_i)
            2'd0:    amt = {3'b000, digit_i};
            2'd1:    amt = {3'b000, digit_i} * 5'd3;
            default: amt = {3'b000, digit_i} * 5'd9;
        endcase

        // Rotation of a doubled word avoids a separate left/right merge.
        rot    = amt[3:0];
        dbl    = {operand_i, operand_i};
        dbl_sh = dbl >> rot;

        case (mode_i)
            MODE_SLL: result_o = operand_i << amt;
            MODE_SRA: result_o = 16'($signed(operand_i) >>> amt);
            MODE_ROR: result_o = dbl_sh[15:0];
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// ----------------------------------------------------------------------------
// shift_seq
// Multi-cycle 16-bit shifter. An accepted command's amount is split into
// three base-3 digits; each SHIFT cycle applies one digit through a single
// reused shift_stage, then the result is presented in DONE until consumed.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : shift_seq_if.slave request/response handshake
//   busy : high whenever the FSM is not in IDLE
// Build option: define SHIFT_SEQ_EARLY_EXIT_EN to leave SHIFT as soon as all
// remaining higher digits are zero (latency 1/2/3 instead of fixed 3).
// ----------------------------------------------------------------------------
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    shift_seq_if.slave bus,
    output logic       busy
);

    state_t          state_q;
    logic [1:0]      k_q;
    logic [15:0]     work_q;
    mode_t           mode_q;
    digits_t         digits_q;
    logic [15:0]     rsp_data_q;
    logic [2:0]      rsp_flag_q;
    logic            rsp_valid_q;
    logic            req_ready_q;
    logic            busy_q;

    digit_t          cur_digit;
    logic [15:0]     work_d;
    logic            last_stage;
    logic [2:0]      flag_d;

    always_comb begin
        case (k_q)
            2'd0:    cur_digit = digits_q.d0;
            2'd1:    cur_digit = digits_q.d1;
            default: cur_digit = digits_q.d2;
        endcase
    end

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    always_comb begin
        case (k_q)
            2'd0:    last_stage = (digits_q.d1 == 2'd0) && (digits_q.d2 == 2'd0);
            2'd1:    last_stage = (digits_q.d2 == 2'd0);
            default: last_stage = 1'b1;
        endcase
    end
`else
    always_comb begin
        last_stage = (k_q == 2'd2);
    end
`endif

    shift_stage u_stage (
        .operand_i (work_q),
        .mode_i    (mode_q),
        .digit_i   (cur_digit),
        .stage_i   (k_q),
        .result_o  (work_d)
    );

    always_comb begin
        flag_d         = '0;
        flag_d[FLAG_Z] = (work_d == 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            work_q      <= '0;
            mode_q      <= MODE_SLL;
            digits_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        work_q      <= bus.req_data;
                        mode_q      <= mode_t'(bus.req_mode);
                        digits_q    <= to_base3(bus.req_amt);
                        k_q         <= '0;
                        state_q     <= ST_SHIFT;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    if (last_stage) begin
                        state_q     <= ST_DONE;
                        rsp_data_q  <= work_d;
                        rsp_flag_q  <= flag_d;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        k_q         <= '0;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flag  = rsp_flag_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_shift_seq.sv
// ----------------------------------------------------------------------------
// tb_shift_seq
// Scoreboard bench for shift_seq: the driver pushes hand-computed expected
// responses, a separate monitor pops and compares on each rising rsp_valid.
// Expected latency follows SHIFT_SEQ_EARLY_EXIT_EN when defined.
// ----------------------------------------------------------------------------
module tb_shift_seq;
    import shift_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    shift_seq_if bus ();

    shift_seq dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic [15:0] data;
        logic        z;
        int unsigned lat;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int unsigned exp_lat(input logic [3:0] amt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (amt <= 4'd2) return 1;
        else if (amt <= 4'd8) return 2;
        else return 3;
`else
        return 3;
`endif
    endfunction

    // Monitor: compare each new response against the scoreboard head.
    initial begin
        logic        prev;
        exp_t        e;
        logic [2:0]  ef;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%h required=no response", bus.rsp_data);
                end else begin
                    e          = sb.pop_front();
                    ef         = '0;
                    ef[FLAG_Z] = e.z;
                    chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    chk("rsp_flag", 32'(bus.rsp_flag), 32'(ef));
                    chk("latency", cyc - e.acc_cyc, e.lat);
                end
            end
            prev = (bus.rsp_valid === 1'b1);
        end
    end

    // Issue one command; caller must be at a negedge. Returns at the negedge
    // right after the accepting edge.
    task automatic issue(input mode_t m, input logic [15:0] d, input logic [3:0] a,
                         input logic [15:0] ed, input logic ez, input bit push);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_amt   = a;
        bus.req_mode  = 2'(m);
        @(negedge clk);
        if (push) sb.push_back('{ed, ez, exp_lat(a), cyc});
        // Scramble inputs so in-flight results cannot depend on them.
        bus.req_valid = 1'b0;
        bus.req_data  = 16'($urandom);
        bus.req_amt   = 4'($urandom);
        bus.req_mode  = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || bus.rsp_valid !== 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_mode  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("rst_rsp_flag",  32'(bus.rsp_flag),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, consumer always ready.
        bus.rsp_ready = 1'b1;
        issue(MODE_SLL,  16'h0001, 4'd15, 16'h8000, 1'b0, 1); wait_idle();
        issue(MODE_SRA,  16'h8000, 4'd4,  16'hF800, 1'b0, 1); wait_idle();
        issue(MODE_ROR,  16'h1234, 4'd4,  16'h4123, 1'b0, 1); wait_idle();
        issue(MODE_SLL,  16'h8000, 4'd1,  16'h0000, 1'b1, 1); wait_idle();
        issue(MODE_RSVD, 16'hFFFF, 4'd5,  16'h0000, 1'b1, 1); wait_idle();
        issue(MODE_SLL,  16'h0003, 4'd2,  16'h000C, 1'b0, 1); wait_idle();
        issue(MODE_SRA,  16'h4000, 4'd3,  16'h0800, 1'b0, 1); wait_idle();
        issue(MODE_ROR,  16'h0001, 4'd9,  16'h0080, 1'b0, 1); wait_idle();
        issue(MODE_SRA,  16'h8001, 4'd0,  16'h8001, 1'b0, 1); wait_idle();
        issue(MODE_ROR,  16'hABCD, 4'd15, 16'h579B, 1'b0, 1); wait_idle();
        issue(MODE_SRA,  16'h8000, 4'd15, 16'hFFFF, 1'b0, 1); wait_idle();

        // Backpressure: hold rsp_ready low for 5 cycles in DONE.
        bus.rsp_ready = 1'b0;
        issue(MODE_ROR, 16'h00F0, 4'd8, 16'hF000, 1'b0, 1);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_data",  32'(bus.rsp_data),  32'h0000F000);
            chk("hold_rsp_flag",  32'(bus.rsp_flag),  32'd0);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
        chk("release_busy",      32'(busy),          32'd0);

        // Reset during the second SHIFT cycle; no response may follow.
        issue(MODE_SLL, 16'h00FF, 4'd15, 16'h0000, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",      32'(busy),          32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("midrst_rsp_flag",  32'(bus.rsp_flag),  32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(MODE_SLL, 16'h0101, 4'd4, 16'h1010, 1'b0, 1); wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
